// File: rtl/corr_pkg.sv
// corr_pkg: shared types, widths and helpers for the correlator window sequencer
package corr_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int RSLT_IDX_W = 16;
  localparam int DROPCNT_W = 8;
  function automatic int countW(input int time_w, input int incr_w);
    return time_w + incr_w - 1;
  endfunction
  localparam int COUNT_W_DEF = countW(8, 16);
  typedef struct packed {
    logic [COUNT_W_DEF-1:0] x;
    logic [COUNT_W_DEF-1:0] y;
    logic [COUNT_W_DEF-1:0] isect;
    logic [COUNT_W_DEF-1:0] symdiff;
    logic [RSLT_IDX_W-1:0]  idx;
  } corr_rslt_t;
endpackage

// File: rtl/corr_window_sequencer_if.sv
// corr_window_sequencer_if: valid/ready result port carrying the four window totals and sequence index
interface corr_window_sequencer_if import corr_pkg::*; #(parameter int COUNT_W = 23) ();
  logic                  valid;
  logic                  ready;
  logic [COUNT_W-1:0]    x;
  logic [COUNT_W-1:0]    y;
  logic [COUNT_W-1:0]    isect;
  logic [COUNT_W-1:0]    symdiff;
  logic [RSLT_IDX_W-1:0] idx;
  modport master(output valid, x, y, isect, symdiff, idx, input ready);
  modport slave(input valid, x, y, isect, symdiff, idx, output ready);
endinterface

// File: rtl/corr_rslt_buf.sv
// corr_rslt_buf: one-deep valid/ready result holder with drop/overrun detect (drop counter under CORR_WINDOW_SEQUENCER_DROPCNT_EN)
module corr_rslt_buf import corr_pkg::*; #(parameter int W = 108) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cg,
  input  logic                 i_pub,
  input  logic                 i_ready,
  input  logic                 i_clr,
  input  logic [W-1:0]         i_data,
  output logic                 o_valid,
  output logic [W-1:0]         o_data,
  output logic                 o_overrun,
  output logic [DROPCNT_W-1:0] o_dropCount
);
  logic         r_valid;
  logic         r_overrun;
  logic [W-1:0] r_data;
  logic         w_drop;
  logic         w_load;
  assign w_drop    = i_pub && r_valid && !i_ready;
  assign w_load    = i_pub && !w_drop;
  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_overrun = r_overrun;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else if (i_cg) begin
      r_valid   <= w_load || (r_valid && !i_ready);
      if (w_load) r_data <= i_data;
      r_overrun <= w_drop || (r_overrun && !i_clr);
    end
  end
`ifdef CORR_WINDOW_SEQUENCER_DROPCNT_EN
  logic [DROPCNT_W-1:0] r_dropCount;
  assign o_dropCount = r_dropCount;
  // a drop coinciding with a clear restarts the count at one
  always_ff @(posedge i_clk) begin
    if (i_rst) r_dropCount <= '0;
    else if (i_cg) r_dropCount <= w_drop ? (i_clr ? DROPCNT_W'(1) : (&r_dropCount ? r_dropCount : r_dropCount + 1'b1))
                                         : (i_clr ? '0 : r_dropCount);
  end
`else
  assign o_dropCount = '0;
`endif
endmodule

// File: rtl/corr_window_sequencer.sv
// corr_window_sequencer: window time index, zero-counts strobe and result publish for a correlator block (CORR_WINDOW_SEQUENCER_DROPCNT_EN enables the drop counter)
module corr_window_sequencer import corr_pkg::*; #(
  parameter  int INCR_W  = 16,
  parameter  int TIME_W  = 8,
  localparam int COUNT_W = countW(TIME_W, INCR_W),
  localparam int EXP_W   = $clog2(TIME_W + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cg,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_oneShot,
  input  logic [EXP_W-1:0]     i_windowLengthExp,
  input  logic                 i_clrOverrun,
  output logic                 o_cg,
  output logic [TIME_W-1:0]    o_t,
  output logic                 o_zeroCounts,
  output logic                 o_busy,
  input  logic [COUNT_W-1:0]   i_countX,
  input  logic [COUNT_W-1:0]   i_countY,
  input  logic [COUNT_W-1:0]   i_countIsect,
  input  logic [COUNT_W-1:0]   i_countSymdiff,
  corr_window_sequencer_if.master rslt,
  output logic                 o_overrun,
  output logic [DROPCNT_W-1:0] o_dropCount
);
  localparam int SPAN_W = TIME_W + 1;
  localparam int DATA_W = 4 * COUNT_W + RSLT_IDX_W;
  state_t                r_state;
  logic [TIME_W-1:0]     r_t;
  logic [EXP_W-1:0]      r_exp;
  logic                  r_first;
  logic                  r_stop;
  logic                  r_wrap;
  logic [RSLT_IDX_W-1:0] r_seq;
  logic [SPAN_W-1:0]     w_span;
  logic                  w_last;
  logic                  w_end;
  logic [DATA_W-1:0]     w_data;
  assign w_span       = SPAN_W'(1) << r_exp;
  assign w_last       = r_t == TIME_W'(w_span - 1'b1);
  assign w_end        = w_last && !r_first && (r_stop || i_stop);
  assign o_cg         = i_cg;
  assign o_t          = r_t;
  assign o_zeroCounts = (r_state == IDLE) || (r_t == '0);
  assign o_busy       = r_state == RUN;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_exp   <= '0;
      r_first <= 1'b0;
      r_stop  <= 1'b0;
      r_wrap  <= 1'b0;
      r_seq   <= '0;
    end else if (i_cg) begin
      r_seq <= r_seq + RSLT_IDX_W'(r_wrap);
      if (r_state == IDLE) begin
        r_t    <= '0;
        r_wrap <= 1'b0;
        if (i_start) begin
          r_state <= RUN;
          r_exp   <= (i_windowLengthExp > EXP_W'(TIME_W)) ? EXP_W'(TIME_W) : i_windowLengthExp;
          r_stop  <= i_oneShot;
          r_first <= 1'b1;
        end
      end else begin
        r_t    <= w_last ? '0 : r_t + 1'b1;
        // the settling first window is never published
        r_wrap <= w_last && !r_first;
        if (w_last) r_first <= 1'b0;
        if (w_end) begin
          r_state <= IDLE;
          r_stop  <= 1'b0;
        end else if (i_stop) r_stop <= 1'b1;
      end
    end
  end
  logic [DATA_W-1:0] w_held;
  assign w_data = {i_countX, i_countY, i_countIsect, i_countSymdiff, r_seq + 1'b1};
  assign {rslt.x, rslt.y, rslt.isect, rslt.symdiff, rslt.idx} = w_held;
  corr_rslt_buf #(.W(DATA_W)) u_buf (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_cg       (i_cg),
    .i_pub      (r_wrap),
    .i_ready    (rslt.ready),
    .i_clr      (i_clrOverrun),
    .i_data     (w_data),
    .o_valid    (rslt.valid),
    .o_data     (w_held),
    .o_overrun  (o_overrun),
    .o_dropCount(o_dropCount)
  );
endmodule

// File: tb/tb_corr_window_sequencer.sv
// tb_corr_window_sequencer: directed scenarios against a simple 1-bit-increment counter block fixture
module tb_corr_window_sequencer;
  import corr_pkg::*;
  localparam int CW = countW(8, 16);
`ifdef CORR_WINDOW_SEQUENCER_DROPCNT_EN
  localparam logic [7:0] DC1 = 8'd1, DC2 = 8'd2;
`else
  localparam logic [7:0] DC1 = 8'd0, DC2 = 8'd0;
`endif
  logic clk = 1'b0, rst, cg, start, stop, one_shot, clr, x, y;
  logic [3:0] wexp;
  logic o_cg, zero, busy, overrun;
  logic [7:0] t, drop_count;
  logic [CW-1:0] cx, cy, ci, cs;
  int n_cmp = 0, n_fail = 0;
  corr_window_sequencer_if #(.COUNT_W(CW)) rif ();
  corr_window_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_start(start), .i_stop(stop), .i_oneShot(one_shot),
    .i_windowLengthExp(wexp), .i_clrOverrun(clr), .o_cg(o_cg), .o_t(t), .o_zeroCounts(zero),
    .o_busy(busy), .i_countX(cx), .i_countY(cy), .i_countIsect(ci), .i_countSymdiff(cs),
    .rslt(rif), .o_overrun(overrun), .o_dropCount(drop_count)
  );
  always #5 clk = ~clk;
  // counter block fixture: zeroCounts restarts the window total with the current sample
  always_ff @(posedge clk) begin
    if (rst) {cx, cy, ci, cs} <= '0;
    else if (o_cg) begin
      cx <= zero ? CW'(x) : cx + CW'(x);
      cy <= zero ? CW'(y) : cy + CW'(y);
      ci <= zero ? CW'(x & y) : ci + CW'(x & y);
      cs <= zero ? CW'(x ^ y) : cs + CW'(x ^ y);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    {start, stop, one_shot, clr, x, y} = '0;
    cg = 1'b1; wexp = 4'd0; rif.ready = 1'b1; rst = 1'b1;
    tick; tick;
    rst = 1'b0;
  endtask
  task automatic begin_run(input logic [3:0] e, input logic os);
    wexp = e; one_shot = os; start = 1'b1;
    tick;
    start = 1'b0; one_shot = 1'b0;
  endtask
  task automatic test_reset;
    do_reset;
    n_cmp++; if (t !== 8'd0) begin n_fail++; $display("FAIL reset_t: got %0d exp 0", t); end
    n_cmp++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b exp 1", zero); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_cmp++; if (rif.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", rif.valid); end
    n_cmp++; if (rif.idx !== 16'd0 || rif.x !== '0 || rif.symdiff !== '0) begin n_fail++; $display("FAIL reset_rslt: idx %0d x %0d sd %0d exp 0", rif.idx, rif.x, rif.symdiff); end
    n_cmp++; if (overrun !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_ovr: ovr %b dc %0d exp 0/0", overrun, drop_count); end
  endtask
  task automatic test_windowing;
    do_reset; x = 1'b1; y = 1'b1;
    begin_run(4'd3, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      tick;
      n_cmp++; if (zero !== (k % 8 == 0)) begin n_fail++; $display("FAIL win_zero k=%0d: got %b", k, zero); end
      n_cmp++; if (rif.valid !== (k >= 17 && (k - 17) % 8 == 0)) begin n_fail++; $display("FAIL win_valid k=%0d: got %b", k, rif.valid); end
      if (k >= 17 && (k - 17) % 8 == 0) begin
        n_cmp++; if (rif.idx !== 16'((k - 9) / 8)) begin n_fail++; $display("FAIL win_idx k=%0d: got %0d exp %0d", k, rif.idx, (k - 9) / 8); end
        n_cmp++; if (rif.x !== CW'(8) || rif.isect !== CW'(8) || rif.symdiff !== '0) begin n_fail++; $display("FAIL win_data k=%0d: x %0d is %0d sd %0d exp 8/8/0", k, rif.x, rif.isect, rif.symdiff); end
      end
    end
  endtask
  task automatic test_oneshot;
    corr_rslt_t er;
    er = '{x: 23'd4, y: 23'd0, isect: 23'd0, symdiff: 23'd4, idx: 16'd1};
    do_reset; x = 1'b1; rif.ready = 1'b0;
    begin_run(4'd2, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      tick;
      if (k == 7) begin n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL os_busy7: got %b exp 1", busy); end end
      if (k == 8) begin n_cmp++; if (busy !== 1'b0 || t !== 8'd0) begin n_fail++; $display("FAIL os_idle: busy %b t %0d exp 0/0", busy, t); end end
      n_cmp++; if (rif.valid !== (k >= 9)) begin n_fail++; $display("FAIL os_valid k=%0d: got %b", k, rif.valid); end
      if (k >= 9) begin n_cmp++; if ({rif.x, rif.y, rif.isect, rif.symdiff, rif.idx} !== er) begin n_fail++; $display("FAIL os_data k=%0d: x %0d y %0d sd %0d idx %0d exp 4/0/4/1", k, rif.x, rif.y, rif.symdiff, rif.idx); end end
    end
    rif.ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick;
      n_cmp++; if (rif.valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL os_after: valid %b busy %b exp 0/0", rif.valid, busy); end
    end
  endtask
  task automatic test_overrun;
    do_reset; y = 1'b1; rif.ready = 1'b0;
    begin_run(4'd4, 1'b0);
    for (int k = 1; k <= 97; k++) begin
      tick;
      if (k >= 33 && k <= 81) begin
        n_cmp++; if (rif.valid !== 1'b1 || rif.x !== '0 || rif.y !== CW'(16) || rif.idx !== 16'd1) begin n_fail++; $display("FAIL ovr_hold k=%0d: v %b x %0d y %0d idx %0d exp 1/0/16/1", k, rif.valid, rif.x, rif.y, rif.idx); end
      end
      if (k == 33) begin n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_33: got %b exp 0", overrun); end end
      if (k == 49) begin n_cmp++; if (overrun !== 1'b1 || drop_count !== DC1) begin n_fail++; $display("FAIL ovr_49: ovr %b dc %0d exp 1/%0d", overrun, drop_count, DC1); end end
      if (k == 65) begin n_cmp++; if (overrun !== 1'b1 || drop_count !== DC2) begin n_fail++; $display("FAIL ovr_65: ovr %b dc %0d exp 1/%0d", overrun, drop_count, DC2); end end
      if (k == 66) begin n_cmp++; if (overrun !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL ovr_clr: ovr %b dc %0d exp 0/0", overrun, drop_count); end end
      if (k == 81) begin n_cmp++; if (overrun !== 1'b1 || drop_count !== DC1) begin n_fail++; $display("FAIL ovr_setwins: ovr %b dc %0d exp 1/%0d", overrun, drop_count, DC1); end end
      if (k == 82) begin n_cmp++; if (rif.valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %b exp 0", rif.valid); end end
      if (k == 97) begin n_cmp++; if (rif.valid !== 1'b1 || rif.x !== CW'(16) || rif.isect !== CW'(16)) begin n_fail++; $display("FAIL ovr_next: v %b x %0d is %0d exp 1/16/16", rif.valid, rif.x, rif.isect); end end
      if (k == 40) x = 1'b1;
      clr = (k == 65 || k == 80);
      if (k == 81) rif.ready = 1'b1;
    end
  endtask
  task automatic test_exp0;
    do_reset;
    begin_run(4'd0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick;
      n_cmp++; if (zero !== 1'b1) begin n_fail++; $display("FAIL e0_zero k=%0d: got %b exp 1", k, zero); end
      n_cmp++; if (rif.valid !== (k >= 3)) begin n_fail++; $display("FAIL e0_valid k=%0d: got %b", k, rif.valid); end
      if (k >= 3) begin n_cmp++; if (rif.idx !== 16'(k - 2) || rif.x !== '0 || rif.y !== '0) begin n_fail++; $display("FAIL e0_data k=%0d: idx %0d x %0d exp %0d/0", k, rif.idx, rif.x, k - 2); end end
    end
  endtask
  task automatic test_clamp_stop;
    do_reset; x = 1'b1;
    begin_run(4'd9, 1'b0);
    for (int k = 1; k <= 513; k++) begin
      tick;
      if (k == 255) begin n_cmp++; if (zero !== 1'b0 || t !== 8'd255) begin n_fail++; $display("FAIL cl_255: zero %b t %0d exp 0/255", zero, t); end end
      if (k == 256) begin n_cmp++; if (zero !== 1'b1) begin n_fail++; $display("FAIL cl_256: got %b exp 1", zero); end end
      if (k == 511) begin n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cl_busy: got %b exp 1", busy); end end
      if (k == 512) begin n_cmp++; if (busy !== 1'b0 || t !== 8'd0) begin n_fail++; $display("FAIL cl_idle: busy %b t %0d exp 0/0", busy, t); end end
      if (k == 513) begin n_cmp++; if (rif.valid !== 1'b1 || rif.x !== CW'(256) || rif.symdiff !== CW'(256) || rif.idx !== 16'd1) begin n_fail++; $display("FAIL cl_rslt: v %b x %0d sd %0d idx %0d exp 1/256/256/1", rif.valid, rif.x, rif.symdiff, rif.idx); end end
      stop = (k == 300);
    end
  endtask
  task automatic test_rst_cg;
    do_reset; rif.ready = 1'b0;
    begin_run(4'd2, 1'b0);
    for (int k = 1; k <= 9; k++) tick;
    n_cmp++; if (rif.valid !== 1'b1) begin n_fail++; $display("FAIL rc_pre: got %b exp 1", rif.valid); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++; if (rif.valid !== 1'b0 || busy !== 1'b0 || t !== 8'd0 || zero !== 1'b1 || rif.idx !== 16'd0) begin n_fail++; $display("FAIL rc_rst: v %b busy %b t %0d zero %b idx %0d exp 0/0/0/1/0", rif.valid, busy, t, zero, rif.idx); end
    begin_run(4'd3, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      tick;
      if (k == 8) begin
        n_cmp++; if (t !== 8'd3 || o_cg !== 1'b0) begin n_fail++; $display("FAIL rc_frozen: t %0d cg %b exp 3/0", t, o_cg); end
        cg = 1'b1;
      end
      if (k == 12) begin n_cmp++; if (zero !== 1'b0 || t !== 8'd7) begin n_fail++; $display("FAIL rc_12: zero %b t %0d exp 0/7", zero, t); end end
      if (k == 13) begin n_cmp++; if (zero !== 1'b1) begin n_fail++; $display("FAIL rc_13: got %b exp 1", zero); end end
      if (k == 3) cg = 1'b0;
    end
  endtask
  initial begin
    test_reset;
    test_windowing;
    test_oneshot;
    test_overrun;
    test_exp0;
    test_clamp_stop;
    test_rst_cg;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
